// File: rtl/game_scoreboard_pkg.sv
// Shared types and 7-segment constants for the game scoreboard.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package game_scoreboard_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StLocked,
    StOver
  } state_e;

  // Width of the value accepted by seg_decode; callers zero-extend into it.
  localparam int unsigned SegValW = 8;

  localparam logic [6:0] Seg0    = 7'h3F;
  localparam logic [6:0] Seg1    = 7'h06;
  localparam logic [6:0] Seg2    = 7'h5B;
  localparam logic [6:0] Seg3    = 7'h4F;
  localparam logic [6:0] Seg4    = 7'h66;
  localparam logic [6:0] Seg5    = 7'h6D;
  localparam logic [6:0] Seg6    = 7'h7D;
  localparam logic [6:0] Seg7    = 7'h07;
  localparam logic [6:0] Seg8    = 7'h7F;
  localparam logic [6:0] Seg9    = 7'h6F;
  localparam logic [6:0] SegDash = 7'h40;

  // Anything above 9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [SegValW-1:0] val);
    logic [6:0] pat;
    pat = SegDash;
    case (val)
      8'd0:    pat = Seg0;
      8'd1:    pat = Seg1;
      8'd2:    pat = Seg2;
      8'd3:    pat = Seg3;
      8'd4:    pat = Seg4;
      8'd5:    pat = Seg5;
      8'd6:    pat = Seg6;
      8'd7:    pat = Seg7;
      8'd8:    pat = Seg8;
      8'd9:    pat = Seg9;
      default: pat = SegDash;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seven_seg_mux.sv
// Two-digit multiplexed 7-segment driver: digit 0 = score, digit 1 = lives.
// SCOREBOARD_BLINK_EN adds blanking of alternate 16-wrap halves while game_over.
module seven_seg_mux
  import game_scoreboard_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned COUNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SCOREBOARD_BLINK_EN
  input  logic               game_start,
  input  logic               game_over,
`endif
  input  logic [COUNT_W-1:0] score,
  input  logic [COUNT_W-1:0] n_lifes,
  output logic [6:0]         seg,
  output logic [1:0]         digit_sel
);

  localparam int unsigned     RefW   = $clog2(REFRESH_DIV);
  localparam logic [RefW-1:0] RefMax = RefW'(REFRESH_DIV - 1);

  logic [RefW-1:0]    refresh_q, refresh_d;
  logic [1:0]         sel_q, sel_d;
  logic [6:0]         seg_q, seg_d;
  logic               wrap;
  logic [COUNT_W-1:0] shown;

`ifdef SCOREBOARD_BLINK_EN
  localparam int unsigned BlinkW = 5;
  logic [BlinkW-1:0] blink_q, blink_d;
`endif

  always_comb begin
    wrap      = (refresh_q == RefMax);
    refresh_d = wrap ? '0 : refresh_q + RefW'(1);
    sel_d     = wrap ? {sel_q[0], sel_q[1]} : sel_q;
    // Decode against the next select so seg and digit_sel change together.
    shown     = sel_d[0] ? score : n_lifes;
    seg_d     = seg_decode(SegValW'(shown));
`ifdef SCOREBOARD_BLINK_EN
    blink_d = blink_q;
    if (game_start) begin
      blink_d = '0;
    end else if (wrap && game_over) begin
      blink_d = blink_q + BlinkW'(1);
    end
    if (game_over && blink_d[BlinkW-1]) begin
      seg_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      sel_q     <= 2'b01;
      seg_q     <= Seg0;
    end else begin
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
    end
  end

`ifdef SCOREBOARD_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`endif

  assign seg       = seg_q;
  assign digit_sel = sel_q;

endmodule

// File: rtl/game_scoreboard.sv
// Score/lives keeper: edge-detects collisions, decides won/lost, drives the display.
// Optional blink of the display on game over: SCOREBOARD_BLINK_EN.
module game_scoreboard
  import game_scoreboard_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 3,
  parameter int unsigned INIT_LIVES  = 3,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned COUNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_start,
  input  logic               round_start,
  input  logic               collision,
  input  logic               collision_bullet,
  output logic [COUNT_W-1:0] score,
  output logic [COUNT_W-1:0] n_lifes,
  output logic               game_over,
  output logic               game_won,
  output logic [6:0]         seg,
  output logic [1:0]         digit_sel
);

  localparam logic [COUNT_W-1:0] WinScore  = COUNT_W'(WIN_SCORE);
  localparam logic [COUNT_W-1:0] InitLives = COUNT_W'(INIT_LIVES);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] score_q, score_d;
  logic [COUNT_W-1:0] lives_q, lives_d;
  logic               over_q, over_d;
  logic               won_q, won_d;

  // Two-stage sampling: the event is seen one cycle after the rise, state
  // updates one cycle later.
  logic coll_q, coll_qq, bull_q, bull_qq;
  logic crash, hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q  <= 1'b0;
      coll_qq <= 1'b0;
      bull_q  <= 1'b0;
      bull_qq <= 1'b0;
    end else begin
      coll_q  <= collision;
      coll_qq <= coll_q;
      bull_q  <= collision_bullet;
      bull_qq <= bull_q;
    end
  end

  assign crash = coll_q & ~coll_qq;
  assign hit   = bull_q & ~bull_qq;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    over_d  = over_q;
    won_d   = won_q;
    if (game_start) begin
      state_d = StPlay;
      score_d = '0;
      lives_d = InitLives;
      over_d  = 1'b0;
      won_d   = 1'b0;
    end else begin
      case (state_q)
        StPlay: begin
          // A crash masks a simultaneous hit.
          if (crash) begin
            lives_d = (lives_q == '0) ? '0 : lives_q - COUNT_W'(1);
            if (lives_d == '0) begin
              state_d = StOver;
              over_d  = 1'b1;
            end else begin
              state_d = StLocked;
            end
          end else if (hit) begin
            score_d = (score_q == WinScore) ? score_q : score_q + COUNT_W'(1);
            if (score_d == WinScore) begin
              state_d = StOver;
              over_d  = 1'b1;
              won_d   = 1'b1;
            end else begin
              state_d = StLocked;
            end
          end
        end
        StLocked: begin
          if (round_start) begin
            state_d = StPlay;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      score_q <= '0;
      lives_q <= '0;
      over_q  <= 1'b0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      over_q  <= over_d;
      won_q   <= won_d;
    end
  end

  seven_seg_mux #(
    .REFRESH_DIV (REFRESH_DIV),
    .COUNT_W     (COUNT_W)
  ) u_seven_seg_mux (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SCOREBOARD_BLINK_EN
    .game_start (game_start),
    .game_over  (over_q),
`endif
    .score      (score_q),
    .n_lifes    (lives_q),
    .seg        (seg),
    .digit_sel  (digit_sel)
  );

  assign score     = score_q;
  assign n_lifes   = lives_q;
  assign game_over = over_q;
  assign game_won  = won_q;

`ifndef SYNTHESIS
  score_bound: assert property (@(posedge clk) disable iff (!rst_n) score_q <= WinScore);
  lives_floor: assert property (@(posedge clk) disable iff (!rst_n)
                                (state_q == StPlay) |-> (lives_q != '0));
  won_implies_over: assert property (@(posedge clk) disable iff (!rst_n) won_q |-> over_q);
`endif

endmodule

// File: tb/tb_game_scoreboard.sv
// Scoreboard bench for game_scoreboard: stimulus queues expected output changes,
// a monitor pops and compares on every observed change and every digit toggle.
module tb_game_scoreboard;

  localparam int unsigned RefreshDiv = 20;

  logic       clk              = 1'b0;
  logic       rst_n            = 1'b1;
  logic       game_start       = 1'b0;
  logic       round_start      = 1'b0;
  logic       collision        = 1'b0;
  logic       collision_bullet = 1'b0;
  logic [3:0] score;
  logic [3:0] n_lifes;
  logic       game_over;
  logic       game_won;
  logic [6:0] seg;
  logic [1:0] digit_sel;

  game_scoreboard #(
    .WIN_SCORE   (3),
    .INIT_LIVES  (3),
    .REFRESH_DIV (RefreshDiv),
    .COUNT_W     (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .game_start       (game_start),
    .round_start      (round_start),
    .collision        (collision),
    .collision_bullet (collision_bullet),
    .score            (score),
    .n_lifes          (n_lifes),
    .game_over        (game_over),
    .game_won         (game_won),
    .seg              (seg),
    .digit_sel        (digit_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] score;
    logic [3:0] lives;
    logic       over;
    logic       won;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rcnt   = 0;

  // Bench-side model of the values the display should currently show.
  logic [3:0] m_score = 4'd0;
  logic [3:0] m_lives = 4'd0;
  logic       m_over  = 1'b0;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    logic [6:0] p;
    p = 7'h40;
    case (v)
      4'd0: p = 7'h3F;
      4'd1: p = 7'h06;
      4'd2: p = 7'h5B;
      4'd3: p = 7'h4F;
      4'd4: p = 7'h66;
      4'd5: p = 7'h6D;
      4'd6: p = 7'h7D;
      4'd7: p = 7'h07;
      4'd8: p = 7'h7F;
      4'd9: p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc  = cyc + 1;
      rcnt = rst_n ? rcnt + 1 : 0;
    end
  end

  // Monitor: value changes pop the expectation queue; digit toggles are timed and
  // the registered seg is compared with the model as it stood before the edge.
  initial begin
    logic [3:0] s_score, s_lives;
    logic       s_over, s_won;
    logic [1:0] s_sel;
    exp_t       e;
    logic [6:0] want_seg;
    s_score = 4'd0;
    s_lives = 4'd0;
    s_over  = 1'b0;
    s_won   = 1'b0;
    s_sel   = 2'b01;
    forever begin
      @(negedge clk);
      if (rst_n && digit_sel != s_sel) begin
        checks++;
        if ((rcnt % RefreshDiv) != 0 || digit_sel != {s_sel[0], s_sel[1]}) begin
          errors++;
          $display("FAIL digit_toggle: got sel=%b at refresh cycle %0d, want sel=%b at a multiple of %0d",
                   digit_sel, rcnt, {s_sel[0], s_sel[1]}, RefreshDiv);
        end
`ifdef SCOREBOARD_BLINK_EN
        if (!m_over) begin
`else
        begin
`endif
          want_seg = seg_ref(digit_sel == 2'b01 ? m_score : m_lives);
          checks++;
          if (seg != want_seg) begin
            errors++;
            $display("FAIL seg_on_toggle: got seg=%h sel=%b, want seg=%h", seg, digit_sel, want_seg);
          end
        end
      end
      s_sel = digit_sel;

      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: no output change seen, want score=%0d lives=%0d over=%0b won=%0b at cycle %0d",
                 e.name, e.score, e.lives, e.over, e.won, e.cyc);
        m_score = e.score;
        m_lives = e.lives;
        m_over  = e.over;
      end

      if (score != s_score || n_lifes != s_lives || game_over != s_over || game_won != s_won) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_change: got score=%0d lives=%0d over=%0b won=%0b at cycle %0d, want no change",
                   score, n_lifes, game_over, game_won, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || score != e.score || n_lifes != e.lives ||
              game_over != e.over || game_won != e.won) begin
            errors++;
            $display("FAIL %s: got score=%0d lives=%0d over=%0b won=%0b at cycle %0d, want score=%0d lives=%0d over=%0b won=%0b at cycle %0d",
                     e.name, score, n_lifes, game_over, game_won, cyc,
                     e.score, e.lives, e.over, e.won, e.cyc);
          end
          m_score = e.score;
          m_lives = e.lives;
          m_over  = e.over;
        end
        s_score = score;
        s_lives = n_lifes;
        s_over  = game_over;
        s_won   = game_won;
      end
    end
  end

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_in(input int d, input int sc, input int lv, input bit ov, input bit wn,
                           input string name);
    exp_t e;
    e.cyc   = cyc + d;
    e.score = 4'(sc);
    e.lives = 4'(lv);
    e.over  = ov;
    e.won   = wn;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic start();
    game_start = 1'b1;
    tick(1);
    game_start = 1'b0;
    tick(1);
  endtask

  task automatic round();
    round_start = 1'b1;
    tick(1);
    round_start = 1'b0;
    tick(1);
  endtask

  task automatic ev_bullet();
    collision_bullet = 1'b1;
    tick(3);
    collision_bullet = 1'b0;
    tick(2);
  endtask

  task automatic ev_crash();
    collision = 1'b1;
    tick(3);
    collision = 1'b0;
    tick(2);
  endtask

`ifdef SCOREBOARD_BLINK_EN
  task automatic wait_toggles(input int n);
    for (int k = 0; k < n; k++) begin
      logic [1:0] s;
      int         b;
      s = digit_sel;
      b = 0;
      while (digit_sel == s && b < 4 * RefreshDiv) begin
        @(negedge clk);
        b++;
      end
      if (digit_sel == s) begin
        checks++;
        errors++;
        $display("FAIL blink_toggle_timeout: got no toggle in %0d cycles, want one", b);
      end
    end
  endtask
`endif

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_score", int'(score), 0);
    check("reset_lives", int'(n_lifes), 0);
    check("reset_over", int'(game_over), 0);
    check("reset_won", int'(game_won), 0);
    check("reset_digit_sel", int'(digit_sel), 1);
    check("reset_seg", int'(seg), 'h3F);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    expect_in(1, 0, 3, 0, 0, "start");
    start();

    // Held hit counts once; re-rise while locked is ignored.
    expect_in(2, 1, 3, 0, 0, "hit_once");
    collision_bullet = 1'b1;
    tick(20);
    collision_bullet = 1'b0;
    tick(2);
    ev_bullet();
    round();
    expect_in(2, 2, 3, 0, 0, "hit_after_round");
    ev_bullet();

    round();
    expect_in(2, 2, 2, 0, 0, "crash1");
    ev_crash();
    round();
    expect_in(2, 2, 1, 0, 0, "crash2");
    ev_crash();
    round();
    expect_in(2, 2, 0, 1, 0, "crash3_lost");
    ev_crash();
    ev_bullet();
    ev_crash();
    round();
    ev_bullet();
    tick(2 * RefreshDiv + 2);

    expect_in(1, 0, 3, 0, 0, "restart_win");
    start();
    expect_in(2, 1, 3, 0, 0, "win_h1");
    ev_bullet();
    round();
    expect_in(2, 2, 3, 0, 0, "win_h2");
    ev_bullet();
    round();
    expect_in(2, 3, 3, 1, 1, "win_h3");
    ev_bullet();
`ifdef SCOREBOARD_BLINK_EN
    wait_toggles(17);
    check("blink_blank", int'(seg), 0);
    wait_toggles(16);
    check("blink_on", int'(seg), 'h4F);
`else
    tick(2 * RefreshDiv + 2);
`endif

    expect_in(1, 0, 3, 0, 0, "restart_simul");
    start();
    expect_in(2, 0, 2, 0, 0, "simul_crash_wins");
    collision        = 1'b1;
    collision_bullet = 1'b1;
    tick(3);
    collision        = 1'b0;
    collision_bullet = 1'b0;
    tick(2);

    // game_start lands in the same cycle as the crash event.
    round();
    collision = 1'b1;
    tick(1);
    game_start = 1'b1;
    expect_in(1, 0, 3, 0, 0, "start_beats_event");
    tick(1);
    game_start = 1'b0;
    tick(2);
    collision = 1'b0;
    tick(2);

    expect_in(2, 1, 3, 0, 0, "pre_reset_hit");
    ev_bullet();
    tick(RefreshDiv + 3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    expect_in(1, 0, 0, 0, 0, "reset_mid");
    #1;
    check("async_rst_score", int'(score), 0);
    check("async_rst_lives", int'(n_lifes), 0);
    check("async_rst_over", int'(game_over), 0);
    check("async_rst_won", int'(game_won), 0);
    check("async_rst_digit_sel", int'(digit_sel), 1);
    check("async_rst_seg", int'(seg), 'h3F);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    expect_in(1, 0, 3, 0, 0, "post_reset_start");
    start();

    tick(5);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_scoreboard.md
Name: game_scoreboard

Overview:
- Downstream consumer of the game master FSM and the sprite collision detectors.
- Turns level-type collision signals into single counted events, and keeps the authoritative score and lives registers.
- Decides game won or lost.
- Drives a two-digit multiplexed 7-segment display: digit 0 shows score, digit 1 shows lives.

Parameters:
- WIN_SCORE, 3, score value that ends the game as won (1..9).
- INIT_LIVES, 3, lives loaded at game start (1..9).
- REFRESH_DIV, 16'd50000, clk cycles per display digit slot (>= 2).
- COUNT_W, 4, width of the score and lives registers.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- game_start  in  1  one-cycle pulse from the master FSM: clear score, load lives, enter play
- round_start  in  1  one-cycle pulse (target write_xy strobe): re-arm event detection
- collision  in  1  level: torpedo overlaps a target
- collision_bullet  in  1  level: bullet overlaps a target
- score  out  COUNT_W  current score
- n_lifes  out  COUNT_W  current lives
- game_over  out  1  high from end of game until the next game_start
- game_won  out  1  high with game_over when the score reached WIN_SCORE
- seg  out  7  segments a..g, active-high
- digit_sel  out  2  one-hot digit enable; bit0 = score, bit1 = lives

Behaviour:
- Reset (rst_n low, asynchronous), all outputs and state:
  - state=IDLE, score=0, n_lifes=0, game_over=0, game_won=0.
  - Refresh counter=0, digit_sel=2'b01, seg=pattern for 0.
- Edge detection:
  - Registered copies of collision and collision_bullet.
  - An event is a 0->1 edge seen in the current cycle.
  - A level held for many cycles counts once.
- States:
  - IDLE: wait for game_start, then go to PLAY. Score=0, lives=INIT_LIVES, flags cleared.
  - PLAY, on a crash edge: n_lifes-1, then ->OVER if the result is 0, else ->LOCKED.
  - PLAY, on a hit edge: score+1, then ->OVER with game_won=1 if the result equals WIN_SCORE, else ->LOCKED.
  - PLAY, simultaneous crash and hit edges: crash wins; the hit is ignored.
  - LOCKED: all events ignored. round_start ->PLAY; game_start re-initialises and ->PLAY.
  - OVER: game_over=1, events ignored. game_start re-initialises and ->PLAY; round_start is ignored.
- game_start in any state has priority over events in the same cycle.
- Update latency: score, n_lifes and flags update on the clock edge after the input edge is sampled, i.e. 2 cycles from the input rise.
- Arithmetic:
  - n_lifes never decrements below 0.
  - score never exceeds WIN_SCORE. The OVER transition guarantees both; add assertions for them.
- Display:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps; at the wrap, digit_sel toggles between 01 and 10.
  - seg is the decimal decode of the selected value, registered, so it is valid in the same cycle digit_sel changes.
  - Values >9 display the "-" pattern (g only).
- Reset mid-game: everything returns to IDLE values immediately; no pending events survive.

Optional Feature:
- Macro: SCOREBOARD_BLINK_EN.
- Defined:
  - While game_over=1, seg is forced to 0 during alternate halves of a blink period of 32 display wraps.
  - Blinking starts with segments on in the first cycle of OVER.
  - The blink counter clears on game_start and on reset.
- Not defined: seg is never blanked, and no blink counter exists.

Decomposition:
- Package game_scoreboard_pkg holds:
  - State enum (IDLE, PLAY, LOCKED, OVER).
  - The 7-bit segment constants for 0..9 and "-".
  - A function mapping COUNT_W values to seg patterns.
- One sub-module: seven_seg_mux. It owns the refresh counter, digit_sel toggling, the decode register and the optional blink, and takes score and n_lifes as inputs.

Test Plan:
- Reset then game_start pulse: score=0, n_lifes=3, game_over=0 two cycles later; digit_sel toggles every 50000 cycles.
- collision_bullet held high 20 cycles in PLAY: score increments exactly once to 1, state LOCKED. A second rise before round_start is ignored; after round_start a new rise makes score=2.
- Three separate crash events, each followed by round_start: n_lifes 3->2->1->0; game_over=1, game_won=0 on the third; further events change nothing.
- Hits to score=3: game_over=1 and game_won=1 in the same cycle the score becomes 3; seg shows 3 while digit_sel=01.
- collision and collision_bullet rise in the same cycle: n_lifes decrements, score unchanged. A game_start coinciding with an edge: state re-initialised, the edge is dropped.
- rst_n dropped mid-LOCKED and asynchronously (between clock edges): all outputs reach reset values before the next clk edge.
- With SCOREBOARD_BLINK_EN defined: seg alternates blank and digit every 16 display wraps while game_over=1.
